// File: rtl/rabbit_keystream_serializer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// rabbit_pkg: shared Rabbit widths, serializer state encoding and keystream extraction.
// Revision 1.0
package rabbit_pkg;

  localparam int RABBIT_WORD_W = 32;
  localparam int RABBIT_BLK_W  = 128;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } rabbit_state_e;

  // s_j mixes one even state word with the halves of two odd words (zero-fill shifts)
  function automatic logic [RABBIT_BLK_W-1:0] rabbit_extract(input logic [255:0] x);
    logic [RABBIT_WORD_W-1:0] w [8];
    for (int i = 0; i < 8; i++) begin
      w[i] = x[i*RABBIT_WORD_W +: RABBIT_WORD_W];
    end
    rabbit_extract = {w[6] ^ (w[3] >> 16) ^ (w[1] << 16),
                      w[4] ^ (w[1] >> 16) ^ (w[7] << 16),
                      w[2] ^ (w[7] >> 16) ^ (w[5] << 16),
                      w[0] ^ (w[5] >> 16) ^ (w[3] << 16)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rabbit_keystream_serializer_if.sv
`default_nettype none
`timescale 1ns/1ps
// rabbit_keystream_serializer_if: state-in and keystream-out handshakes.
// Revision 1.0
interface rabbit_keystream_serializer_if #(parameter int OUT_W = 32);

  logic             st_valid;
  logic             st_ready;
  logic [255:0]     st_x;
  logic             ks_valid;
  logic             ks_ready;
  logic [OUT_W-1:0] ks_data;
  logic             ks_last;

  modport master (
    output st_valid, st_x, ks_ready,
    input  st_ready, ks_valid, ks_data, ks_last
  );

  modport slave (
    input  st_valid, st_x, ks_ready,
    output st_ready, ks_valid, ks_data, ks_last
  );

endinterface
`default_nettype wire

// File: rtl/rabbit_keystream_serializer_extract.sv
`default_nettype none
`timescale 1ns/1ps
// rabbit_extract_comb: pure combinational keystream extraction from the Rabbit inner state.
// Revision 1.0
module rabbit_extract_comb
  import rabbit_pkg::*;
(
  input  logic [255:0]              x,
  output logic [RABBIT_BLK_W-1:0]   s
);

  assign s = rabbit_extract(x);

endmodule
`default_nettype wire

// File: rtl/rabbit_keystream_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// rabbit_keystream_serializer: buffers one extracted 128-bit block and streams it LSB-first
// as OUT_W-bit beats, with back-to-back reload, flush and a delivered-block counter. Rev 1.0
module rabbit_keystream_serializer
  import rabbit_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  rabbit_keystream_serializer_if.slave bus,
  input  logic                         flush,
  output logic [CNT_W-1:0]             blk_count
);

  localparam int BEATS  = RABBIT_BLK_W / OUT_W;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOTS  = 1 << BIDX_W;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic [0:0]              state;
  logic [BIDX_W-1:0]       beat;
  logic [RABBIT_BLK_W-1:0] blk_q;
  logic [RABBIT_BLK_W-1:0] ext_blk;
  logic [OUT_W-1:0]        slot [SLOTS];
  logic                    in_send;
  logic                    last_beat;
  logic                    fire;
  logic                    take;

  rabbit_extract_comb u_extract (
    .x (bus.st_x),
    .s (ext_blk)
  );

  // Beat-indexed view of the held block; unused slots exist only when BEATS == 1
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < BEATS) begin : g_used
      assign slot[i] = blk_q[i*OUT_W +: OUT_W];
    end else begin : g_pad
      assign slot[i] = '0;
    end
  end

  assign in_send   = (state == ST_SEND);
  assign last_beat = in_send && (beat == BIDX_W'(BEATS - 1));
  assign fire      = in_send && bus.ks_ready;

  assign bus.ks_valid = in_send;
  assign bus.ks_last  = last_beat;
  assign bus.ks_data  = slot[beat];

  // A new state may land on the same edge the final beat leaves; flush blocks it
  assign bus.st_ready = !flush && (!in_send || (last_beat && bus.ks_ready));
  assign take         = bus.st_valid && bus.st_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat      <= '0;
      blk_q     <= '0;
      blk_count <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      if (take) begin
        blk_q <= ext_blk;
        beat  <= '0;
        state <= ST_SEND;
      end else if (fire && last_beat) begin
        state <= ST_IDLE;
      end else if (fire) begin
        beat <= beat + BIDX_W'(1);
      end

      if (fire && last_beat) begin
        blk_count <= blk_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rabbit_keystream_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench: three serializer widths share clk/rst; stimulus queues expected beats,
// negedge monitors pop and compare on every ks handshake.
module tb_rabbit_keystream_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rabbit_keystream_serializer_if #(.OUT_W(32))  if32 ();
  rabbit_keystream_serializer_if #(.OUT_W(64))  if64 ();
  rabbit_keystream_serializer_if #(.OUT_W(128)) if128 ();

  logic        fl32 = 1'b0, fl64 = 1'b0, fl128 = 1'b0;
  logic [15:0] cnt32, cnt64, cnt128;

  rabbit_keystream_serializer #(.OUT_W(32), .CNT_W(16)) u32 (
    .clk(clk), .rst(rst), .bus(if32), .flush(fl32), .blk_count(cnt32));
  rabbit_keystream_serializer #(.OUT_W(64), .CNT_W(16)) u64 (
    .clk(clk), .rst(rst), .bus(if64), .flush(fl64), .blk_count(cnt64));
  rabbit_keystream_serializer #(.OUT_W(128), .CNT_W(16)) u128 (
    .clk(clk), .rst(rst), .bus(if128), .flush(fl128), .blk_count(cnt128));

  int errors = 0;
  int checks = 0;

  logic [32:0]  q32 [$];
  logic [64:0]  q64 [$];
  logic [128:0] q128 [$];
  logic [32:0]  e32;
  logic [64:0]  e64;
  logic [128:0] e128;

  int v64 = 0, r64 = 0, gap64 = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkx(input logic [31:0] x0, input logic [31:0] x1,
                                       input logic [31:0] x2, input logic [31:0] x3,
                                       input logic [31:0] x4, input logic [31:0] x5,
                                       input logic [31:0] x6, input logic [31:0] x7);
    return {x7, x6, x5, x4, x3, x2, x1, x0};
  endfunction

  function automatic logic rdy(input int w);
    case (w)
      0:       return if32.st_ready;
      1:       return if64.st_ready;
      default: return if128.st_ready;
    endcase
  endfunction

  // Present a state, wait (bounded) for acceptance, return #1 after the accepting edge
  task automatic offer(input int w, input logic [255:0] x);
    logic got;
    got = 1'b0;
    case (w)
      0:       begin if32.st_x  = x; if32.st_valid  = 1'b1; end
      1:       begin if64.st_x  = x; if64.st_valid  = 1'b1; end
      default: begin if128.st_x = x; if128.st_valid = 1'b1; end
    endcase
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdy(w);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_w%0d: st_ready stayed 0, expected 1 within 20 cycles", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() + q64.size() + q128.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((q32.size() + q64.size() + q128.size()) != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, expected 0",
               q32.size() + q64.size() + q128.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && if32.ks_valid && if32.ks_ready) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL beat32: unexpected beat last=%b data=%h", if32.ks_last, if32.ks_data);
      end else begin
        e32 = q32.pop_front();
        if ({if32.ks_last, if32.ks_data} !== e32) begin
          errors++;
          $display("FAIL beat32: got last=%b data=%h expected last=%b data=%h",
                   if32.ks_last, if32.ks_data, e32[32], e32[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if64.ks_valid && if64.ks_ready) begin
      checks++;
      if (q64.size() == 0) begin
        errors++;
        $display("FAIL beat64: unexpected beat last=%b data=%h", if64.ks_last, if64.ks_data);
      end else begin
        e64 = q64.pop_front();
        if ({if64.ks_last, if64.ks_data} !== e64) begin
          errors++;
          $display("FAIL beat64: got last=%b data=%h expected last=%b data=%h",
                   if64.ks_last, if64.ks_data, e64[64], e64[63:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if128.ks_valid && if128.ks_ready) begin
      checks++;
      if (q128.size() == 0) begin
        errors++;
        $display("FAIL beat128: unexpected beat last=%b data=%h", if128.ks_last, if128.ks_data);
      end else begin
        e128 = q128.pop_front();
        if ({if128.ks_last, if128.ks_data} !== e128) begin
          errors++;
          $display("FAIL beat128: got last=%b data=%h expected last=%b data=%h",
                   if128.ks_last, if128.ks_data, e128[128], e128[127:0]);
        end
      end
    end
  end

  // Activity of the 64-bit instance: valid cycles, st_ready pulses, idle gaps mid-stream
  always @(negedge clk) begin
    if (!rst) begin
      if (if64.ks_valid) v64++;
      if (if64.ks_valid && if64.st_ready) r64++;
      if (!if64.ks_valid && (cnt64 == 16'd1 || cnt64 == 16'd2)) gap64++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    if32.st_valid  = 1'b0; if32.st_x  = '0; if32.ks_ready  = 1'b0;
    if64.st_valid  = 1'b0; if64.st_x  = '0; if64.ks_ready  = 1'b0;
    if128.st_valid = 1'b0; if128.st_x = '0; if128.ks_ready = 1'b0;

    #12;
    chk("rst_ks_valid32", 128'(if32.ks_valid), 128'(0));
    chk("rst_ks_last32",  128'(if32.ks_last),  128'(0));
    chk("rst_ks_data32",  128'(if32.ks_data),  128'(0));
    chk("rst_st_ready32", 128'(if32.st_ready), 128'(1));
    chk("rst_count32",    128'(cnt32),         128'(0));
    chk("rst_ks_data128", if128.ks_data,       128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single block, 32-bit beats
    if32.ks_ready = 1'b1;
    q32.push_back({1'b0, 32'hDEADBEEF});
    q32.push_back({1'b0, 32'h0});
    q32.push_back({1'b0, 32'h0});
    q32.push_back({1'b1, 32'h0});
    offer(0, mkx(32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
    if32.st_valid = 1'b0;
    drain();
    chk("count32_single", 128'(cnt32), 128'(1));

    // Extraction with shifted words, 128-bit beat
    if128.ks_ready = 1'b1;
    q128.push_back({1'b1, 128'h00000000_00000000_55550000_BEEFAAAA});
    offer(2, mkx(0, 0, 0, 32'h0000BEEF, 0, 32'hAAAA5555, 0, 0));
    if128.st_valid = 1'b0;
    drain();
    chk("count128", 128'(cnt128), 128'(1));

    // Back-to-back blocks, 64-bit beats
    if64.ks_ready = 1'b1;
    q64.push_back({1'b0, 64'h22222222_11111111});
    q64.push_back({1'b1, 64'h44444444_33333333});
    q64.push_back({1'b0, 64'h89ABCDEF_01234567});
    q64.push_back({1'b1, 64'hFFFFFFFF_00000000});
    q64.push_back({1'b0, 64'h00000000_00000000});
    q64.push_back({1'b1, 64'h56780000_00001234});
    offer(1, mkx(32'h11111111, 0, 32'h22222222, 0, 32'h33333333, 0, 32'h44444444, 0));
    offer(1, mkx(32'h01234567, 0, 32'h89ABCDEF, 0, 32'h0, 0, 32'hFFFFFFFF, 0));
    offer(1, mkx(0, 32'h12345678, 0, 0, 0, 0, 0, 0));
    if64.st_valid = 1'b0;
    drain();
    chk("count64_b2b",   128'(cnt64), 128'(3));
    chk("valid64_cycles", 128'(v64),  128'(6));
    chk("ready64_pulses", 128'(r64),  128'(3));
    chk("gap64_cycles",   128'(gap64), 128'(0));

    // Backpressure on the second beat
    q32.push_back({1'b0, 32'h01010101});
    q32.push_back({1'b0, 32'h02020202});
    q32.push_back({1'b0, 32'h03030303});
    q32.push_back({1'b1, 32'h04040404});
    offer(0, mkx(32'h01010101, 0, 32'h02020202, 0, 32'h03030303, 0, 32'h04040404, 0));
    if32.st_valid = 1'b0;
    @(posedge clk);
    #1;
    if32.ks_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data",     128'(if32.ks_data),  128'(32'h02020202));
      chk("bp_last",     128'(if32.ks_last),  128'(0));
      chk("bp_st_ready", 128'(if32.st_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    if32.ks_ready = 1'b1;
    drain();
    chk("count32_bp", 128'(cnt32), 128'(2));

    // Flush on the final beat with a competing new state
    q32.push_back({1'b0, 32'h0F0F0F0F});
    q32.push_back({1'b0, 32'h0});
    q32.push_back({1'b0, 32'h0});
    q32.push_back({1'b1, 32'h0});
    offer(0, mkx(32'h0F0F0F0F, 0, 0, 0, 0, 0, 0, 0));
    if32.st_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    fl32 = 1'b1;
    if32.st_x = mkx(32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    if32.st_valid = 1'b1;
    @(negedge clk);
    chk("flush_last",     128'(if32.ks_last),  128'(1));
    chk("flush_st_ready", 128'(if32.st_ready), 128'(0));
    @(posedge clk);
    #1;
    fl32 = 1'b0;
    if32.st_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_valid", 128'(if32.ks_valid), 128'(0));
    chk("flush_count",      128'(cnt32),         128'(2));
    chk("flush_st_ready1",  128'(if32.st_ready), 128'(1));
    drain();

    // Asynchronous reset mid-block
    q32.push_back({1'b0, 32'hCAFEBABE});
    offer(0, mkx(32'hCAFEBABE, 0, 0, 0, 0, 0, 0, 0));
    if32.st_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(if32.ks_valid), 128'(0));
    chk("arst_count", 128'(cnt32),         128'(0));
    chk("arst_data",  128'(if32.ks_data),  128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_st_ready", 128'(if32.st_ready), 128'(1));
    chk("post_rst_valid",    128'(if32.ks_valid), 128'(0));
    chk("post_rst_count64",  128'(cnt64),         128'(0));
    chk("queues_empty", 128'(q32.size() + q64.size() + q128.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rabbit_keystream_serializer.md
# rabbit_keystream_serializer

Sequential successor to the Rabbit combinational keystream extractor. Accepts one 256-bit Rabbit inner state (x0..x7) per handshake and forms the 128-bit keystream block s0..s3. It then streams that block out as OUT_W-bit beats over a valid/ready interface. The block sits between the Rabbit next-state/counter core and the XOR datapath, and adds buffering, back-to-back block throughput, flush and a delivered-block counter.

## Interface
Parameters:
- OUT_W, 32, output beat width; legal values 32, 64, 128.
- CNT_W, 16, width of the delivered-block counter.

Ports:
- clk  in  1  single clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  state word bus valid.
- st_ready  out  1  block can accept a state.
- st_x  in  256  inner state; x0 = [31:0], x1 = [63:32], …, x7 = [255:224].
- ks_valid  out  1  keystream beat valid.
- ks_ready  in  1  downstream accepts beat.
- ks_data  out  OUT_W  keystream beat.
- ks_last  out  1  beat is the final beat of a 128-bit block.
- flush  in  1  synchronous discard of any held block.
- blk_count  out  CNT_W  number of fully delivered blocks, modulo 2^CNT_W.

## Operation
- Derived constant: BEATS = 128/OUT_W, giving 4, 2 or 1 beats per block. BIDX_W = max(1, log2(BEATS)).
- Extraction, all 32-bit with zero-fill shifts:
  - s0 = x0 ^ (x5>>16) ^ (x3<<16)
  - s1 = x2 ^ (x7>>16) ^ (x5<<16)
  - s2 = x4 ^ (x1>>16) ^ (x7<<16)
  - s3 = x6 ^ (x3>>16) ^ (x1<<16)
  - The extracted block is S = {s3, s2, s1, s0}.
- Two-state FSM, IDLE and SEND.
- IDLE:
  - st_ready = 1, ks_valid = 0.
  - On st_valid: register S into blk_q, set beat = 0, go to SEND.
- SEND:
  - ks_valid = 1.
  - ks_data = blk_q[beat*OUT_W +: OUT_W]. Beats go out LSB first, so s0 leaves first.
  - ks_last = (beat == BEATS-1).
- On ks_valid & ks_ready with ks_last = 0: beat increments.
- On ks_valid & ks_ready with ks_last = 1:
  - blk_count increments; it wraps at 2^CNT_W.
  - If st_valid is also high: load the new S, set beat = 0, stay in SEND (back-to-back).
  - Otherwise go to IDLE.
- st_ready = (state == IDLE) | (state == SEND & ks_last & ks_ready), gated low by flush.
  - This is a combinational path from ks_ready to st_ready and is allowed.
- ks_data, ks_valid and ks_last are driven from registers only; no combinational path from st_* to ks_*.
- flush has the highest priority:
  - next state = IDLE, beat = 0.
  - No count increment, even if the final beat handshakes in the same cycle.
  - st_ready = 0 in that cycle, so a state presented during flush is not taken.
- ks_data must hold stable while ks_valid & !ks_ready (AXI-stream rules).

## Timing
- Reset values: state IDLE, beat 0, blk_q 0, blk_count 0, ks_valid 0, ks_last 0, ks_data 0, st_ready 1.
- Latency: state accepted at edge N, first beat valid after edge N, i.e. visible in cycle N+1.
- Throughput with ks_ready held high: one block per BEATS cycles, with no idle cycle between blocks.
- OUT_W = 128: every beat is ks_last, giving a sustained 1 block/cycle.
- Backpressure: with ks_ready low, the beat and data freeze indefinitely and st_ready stays low.
- Reset asserted mid-block: outputs return to reset values immediately (asynchronous), the block is lost, and the counter is cleared.
- blk_count updates on the edge that completes the final handshake.

## Structure
- Shared package rabbit_pkg holds:
  - RABBIT_WORD_W = 32 and RABBIT_BLK_W = 128.
  - The state enum {IDLE, SEND}.
  - A function rabbit_extract(logic [255:0]) returning [127:0], reused by later Rabbit blocks.
- Natural sub-module: rabbit_extract_comb, the pure combinational extraction instantiated on st_x.
- The top module holds the FSM, beat counter, block register and blk_count.

## Test plan
- Single block, OUT_W = 32, ks_ready = 1, st_x all zero except x0 = 0xDEADBEEF:
  - beats are 0xDEADBEEF, 0, 0, 0.
  - ks_last only on beat 4; blk_count = 1.
- Extraction check, OUT_W = 128, with x5 = 0xAAAA5555, x3 = 0x0000BEEF, all others 0:
  - ks_data = {0x00000000, 0x00000000, 0x55550000, 0xBEEFAAAA}, with ks_last = 1.
- Back-to-back, OUT_W = 64, st_valid held high for 3 blocks with ks_ready = 1:
  - ks_valid continuous for 6 cycles.
  - st_ready pulses on the ks_last cycles; blk_count = 3.
- Backpressure: drop ks_ready for 5 cycles on beat 2:
  - ks_data and ks_last stay stable, st_ready stays 0.
  - Beats resume in order, with none duplicated or lost.
- Flush on the final beat with ks_ready = 1 and st_valid = 1:
  - next cycle is IDLE, blk_count unchanged, new state not accepted.
- Async reset mid-SEND:
  - ks_valid falls with no clock edge.
  - blk_count = 0, and st_ready = 1 once reset is released.
